// File: rtl/hwregs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hwregs: memory-mapped LED/7-seg/switch/timer/UART-FIFO responder.    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module hwregs #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_hwregs_req,
    input  logic [31:0] cpud_addr,
    input  logic        cpud_write,
    input  logic [3:0]  cpud_wstrb,
    input  logic [31:0] cpud_wdata,
    output logic        cpu_hwregs_ack,
    output logic [31:0] cpu_hwregs_rdata,
    input  logic [9:0]  sw,
    output logic [9:0]  led,
    output logic [23:0] seven_seg,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [13:0] IDX_SEG   = 14'd0;
    localparam logic [13:0] IDX_LED   = 14'd1;
    localparam logic [13:0] IDX_SW    = 14'd2;
    localparam logic [13:0] IDX_UART  = 14'd3;
    localparam logic [13:0] IDX_TIMER = 14'd4;

    logic [13:0]      reg_idx;
    logic             is_write;
    logic             is_read;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             full;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] free_slots;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       mem [FIFO_DEPTH];
    logic             overflow;
    logic [31:0]      timer;
    logic [9:0]       sw_meta;
    logic [9:0]       sw_sync;
    logic [31:0]      read_data;
    logic             unused_bits;

    assign unused_bits = ^{cpud_addr[31:16], cpud_addr[1:0], cpud_wdata[31:24], cpud_wstrb[3]};

    assign reg_idx  = cpud_addr[15:2];
    assign is_write = cpu_hwregs_req && cpud_write;
    assign is_read  = cpu_hwregs_req && !cpud_write;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = (count != '0) && uart_tx_ready;
    assign push_req = is_write && (reg_idx == IDX_UART) && cpud_wstrb[0];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Free-slot reads report occupancy as it stands after the request edge.
    assign free_slots = CNT_W'(FIFO_DEPTH) - count_next;

    always_comb begin
        read_data = 32'h0;
        case (reg_idx)
            IDX_SEG:   read_data = {8'h00, seven_seg};
            IDX_LED:   read_data = {22'h0, led};
            IDX_SW:    read_data = {22'h0, sw_sync};
            IDX_UART:  read_data = {overflow, 15'h0, {(16 - CNT_W){1'b0}}, free_slots};
            IDX_TIMER: read_data = timer;
            default:   read_data = 32'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cpu_hwregs_ack   <= 1'b0;
            cpu_hwregs_rdata <= 32'h0;
            led              <= 10'h0;
            seven_seg        <= 24'h0;
            timer            <= 32'h0;
            sw_meta          <= 10'h0;
            sw_sync          <= 10'h0;
            overflow         <= 1'b0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
        end else begin
            cpu_hwregs_ack   <= cpu_hwregs_req;
            cpu_hwregs_rdata <= is_read ? read_data : 32'h0;

            if (is_write && (reg_idx == IDX_TIMER)) begin
                timer <= 32'h0;
            end else begin
                timer <= timer + 32'd1;
            end

            sw_meta <= sw;
            sw_sync <= sw_meta;

            if (is_write && (reg_idx == IDX_SEG)) begin
                if (cpud_wstrb[0]) seven_seg[7:0]   <= cpud_wdata[7:0];
                if (cpud_wstrb[1]) seven_seg[15:8]  <= cpud_wdata[15:8];
                if (cpud_wstrb[2]) seven_seg[23:16] <= cpud_wdata[23:16];
            end

            if (is_write && (reg_idx == IDX_LED)) begin
                if (cpud_wstrb[0]) led[7:0] <= cpud_wdata[7:0];
                if (cpud_wstrb[1]) led[9:8] <= cpud_wdata[9:8];
            end

            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end else if (is_read && (reg_idx == IDX_UART)) begin
                overflow <= 1'b0;
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= cpud_wdata[7:0];
        end
    end

    assign uart_tx_valid = (count != '0);
    assign uart_tx_data  = (count != '0) ? mem[rd_ptr] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_hwregs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hwregs: randomized and directed bench with a queue-based model.   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_hwregs;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        write = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        ack;
    logic [31:0] rdata;
    logic [9:0]  sw = 10'h0;
    logic [9:0]  led;
    logic [23:0] seven_seg;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [9:0]  m_led;
    logic [23:0] m_seg;
    logic [31:0] m_timer;
    logic        m_ovf;
    logic [9:0]  m_sw1;
    logic [9:0]  m_sw2;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic [7:0]  q[$];
    logic [7:0]  out_q[$];

    hwregs #(.FIFO_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cpu_hwregs_req   (req),
        .cpud_addr        (addr),
        .cpud_write       (write),
        .cpud_wstrb       (wstrb),
        .cpud_wdata       (wdata),
        .cpu_hwregs_ack   (ack),
        .cpu_hwregs_rdata (rdata),
        .sw               (sw),
        .led              (led),
        .seven_seg        (seven_seg),
        .uart_tx_valid    (tx_valid),
        .uart_tx_data     (tx_data),
        .uart_tx_ready    (tx_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock with the currently driven inputs, updating the model.
    task automatic step();
        logic [13:0] idx;
        logic [31:0] rd;
        logic        pop;
        idx = addr[15:2];
        rd  = 32'h0;
        if (!reset_n) begin
            m_led = 0; m_seg = 0; m_timer = 0; m_ovf = 0;
            m_sw1 = 0; m_sw2 = 0; m_ack = 0; m_rdata = 0;
            q.delete();
        end else begin
            pop = (q.size() != 0) && tx_ready;
            if (pop) begin
                out_q.push_back(q[0]);
                void'(q.pop_front());
            end
            if (req && !write) begin
                if (idx == 0)      rd = {8'h0, m_seg};
                else if (idx == 1) rd = {22'h0, m_led};
                else if (idx == 2) rd = {22'h0, m_sw2};
                else if (idx == 3) rd = {m_ovf, 15'h0, 16'(DEPTH - q.size())};
                else if (idx == 4) rd = m_timer;
                if (idx == 3) m_ovf = 1'b0;
            end
            if (req && write) begin
                if (idx == 0) begin
                    if (wstrb[0]) m_seg[7:0]   = wdata[7:0];
                    if (wstrb[1]) m_seg[15:8]  = wdata[15:8];
                    if (wstrb[2]) m_seg[23:16] = wdata[23:16];
                end
                if (idx == 1) begin
                    if (wstrb[0]) m_led[7:0] = wdata[7:0];
                    if (wstrb[1]) m_led[9:8] = wdata[9:8];
                end
                if (idx == 3 && wstrb[0]) begin
                    if (q.size() < DEPTH) q.push_back(wdata[7:0]);
                    else m_ovf = 1'b1;
                end
            end
            m_timer = (req && write && idx == 4) ? 32'h0 : m_timer + 32'd1;
            m_sw2   = m_sw1;
            m_sw1   = sw;
            m_ack   = req;
            m_rdata = rd;
        end
        @(posedge clock);
        #1;
        chk("ack", {31'h0, ack}, {31'h0, m_ack});
        chk("rdata", rdata, m_rdata);
        chk("led", {22'h0, led}, {22'h0, m_led});
        chk("seven_seg", {8'h0, seven_seg}, {8'h0, m_seg});
        chk("tx_valid", {31'h0, tx_valid}, {31'h0, (q.size() != 0)});
        chk("tx_data", {24'h0, tx_data}, {24'h0, (q.size() != 0) ? q[0] : 8'h00});
        req = 1'b0;
        write = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic acc(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        req = 1'b1; write = w; addr = a; wstrb = s; wdata = d;
        step();
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && q.size() != 0; i++) step();
        step();
        chk("drained", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] offs [8];
        logic [15:0] off;
        offs = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h40, 16'h00};

        // Reset
        reset_n = 1'b0;
        sw = 10'h2A5;
        step();
        step();
        reset_n = 1'b1;
        acc(1'b0, 32'hE000_000C, 4'h0, 32'h0);
        chk("reset_uart_free", rdata, 32'h0000_0010);

        // LED byte strobes
        acc(1'b1, 32'hE000_0004, 4'b0001, 32'h3FF);
        acc(1'b0, 32'hE000_0004, 4'h0, 32'h0);
        chk("led_strobe0", rdata, 32'h0FF);
        acc(1'b1, 32'hE000_0004, 4'b0010, 32'h200);
        acc(1'b0, 32'hE000_0004, 4'h0, 32'h0);
        chk("led_strobe1", rdata, 32'h2FF);

        // Switch synchroniser and unmapped read
        acc(1'b0, 32'hE000_0008, 4'h0, 32'h0);
        chk("switches", rdata, 32'h2A5);
        acc(1'b0, 32'hE000_0040, 4'h0, 32'h0);
        chk("unmapped_ack", {31'h0, ack}, 32'h1);
        chk("unmapped_rdata", rdata, 32'h0);
        step();

        // Random accesses
        for (int i = 0; i < 100; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tx_ready = 1'($urandom);
                step();
            end
            off = offs[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) off = 16'($urandom);
            if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
            tx_ready = 1'($urandom);
            acc(1'($urandom), {16'($urandom), off}, 4'($urandom), $urandom);
        end

        // FIFO overflow
        drain();
        acc(1'b0, 32'hE000_000C, 4'h0, 32'h0);
        for (int i = 0; i < 17; i++) acc(1'b1, 32'hE000_000C, 4'h1, 32'(8'h41 + i));
        acc(1'b0, 32'hE000_000C, 4'h0, 32'h0);
        chk("overflow_read", rdata, 32'h8000_0000);
        acc(1'b0, 32'hE000_000C, 4'h0, 32'h0);
        chk("overflow_cleared", rdata, 32'h0000_0000);
        out_q.delete();
        drain();
        chk("overflow_out_count", out_q.size(), 32'd16);
        for (int i = 0; i < 16 && i < out_q.size(); i++)
            chk("overflow_out_byte", {24'h0, out_q[i]}, 32'(8'h41 + i));

        // Full FIFO push and pop in the same cycle
        for (int i = 0; i < 16; i++) acc(1'b1, 32'hE000_000C, 4'h1, 32'(8'h60 + i));
        tx_ready = 1'b1;
        acc(1'b1, 32'hE000_000C, 4'h1, 32'h99);
        tx_ready = 1'b0;
        acc(1'b0, 32'hE000_000C, 4'h0, 32'h0);
        chk("full_pushpop_status", rdata, 32'h0000_0000);
        out_q.delete();
        drain();
        chk("full_pushpop_count", out_q.size(), 32'd16);
        if (out_q.size() != 0) chk("full_pushpop_last", {24'h0, out_q[out_q.size() - 1]}, 32'h99);

        // Timer clear and wrap
        acc(1'b1, 32'hE000_0010, 4'hF, 32'h1234);
        step();
        acc(1'b0, 32'hE000_0010, 4'h0, 32'h0);
        chk("timer_after_clear", rdata, 32'd1);
        force dut.timer = 32'hFFFF_FFFE;
        #1;
        release dut.timer;
        m_timer = 32'hFFFF_FFFE;
        step();
        acc(1'b0, 32'hE000_0010, 4'h0, 32'h0);
        chk("timer_max", rdata, 32'hFFFF_FFFF);
        acc(1'b0, 32'hE000_0010, 4'h0, 32'h0);
        chk("timer_wrap", rdata, 32'h0);

        // Reset during a request drops the ack
        req = 1'b1; write = 1'b0; addr = 32'hE000_0004;
        reset_n = 1'b0;
        step();
        chk("reset_drops_ack", {31'h0, ack}, 32'h0);
        reset_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hwregs.md
# hwregs

Memory-mapped hardware-register responder occupying the 0xE000xxxx window of the CPU data bus. It accepts the single-cycle `cpu_hwregs_req` strobe produced by the address decoder, performs the read or write, and returns `cpu_hwregs_ack` with `cpu_hwregs_rdata` exactly one cycle later. It owns the board LEDs and seven-segment display, samples the switches, runs a free-running cycle timer, and buffers bytes for the UART transmitter in a small FIFO.

## Interface
- FIFO_DEPTH, 16, UART TX FIFO entries; power of two, 2..256.
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_hwregs_req  in  1  one-cycle request strobe from address decoder
- cpud_addr  in  32  byte address; only [15:2] decoded
- cpud_write  in  1  1 = write, 0 = read; valid in req cycle
- cpud_wstrb  in  4  byte write enables; valid in req cycle
- cpud_wdata  in  32  write data; valid in req cycle
- cpu_hwregs_ack  out  1  one-cycle acknowledge
- cpu_hwregs_rdata  out  32  read data; all-zero whenever ack is low (bus is OR-merged)
- sw  in  10  board switches
- led  out  10  LED drive
- seven_seg  out  24  six 4-bit hex digits
- uart_tx_valid  out  1  FIFO head valid
- uart_tx_data  out  8  FIFO head byte
- uart_tx_ready  in  1  UART transmitter accepts head

## Operation
- Register map (offset = addr[15:0]):
  - 0x00 SEVEN_SEG RW, bits [23:0]; wstrb[0..2] gate bytes 0..2; reads [31:24]=0.
  - 0x04 LED RW, bits [9:0]; wstrb[0] gates [7:0], wstrb[1] gates [9:8].
  - 0x08 SWITCHES RO, [9:0]=sw sampled through a 2-flop synchroniser; writes ignored.
  - 0x0C UART RW. Write with wstrb[0]=1 pushes wdata[7:0]. Read: [15:0] = free slots (FIFO_DEPTH − count), [31] = sticky overflow, others 0. A read clears overflow.
  - 0x10 TIMER RW. Read returns counter value at the req edge. Any write clears counter to 0.
  - All other offsets: read 0, write ignored, still acked.
- Every req produces exactly one ack; no error response.
- Timer: 32-bit, +1 every cycle, wraps 0xFFFFFFFF→0. Write in cycle N: value 0 after edge N, 1 after N+1.
- FIFO: circular buffer, pointers modulo FIFO_DEPTH, count 0..FIFO_DEPTH.
  - uart_tx_valid = (count != 0); uart_tx_data = head; pop when valid && ready.
  - Push when full and no pop in same cycle: byte dropped, overflow set.
  - Push and pop same cycle when full: both occur, count unchanged, no overflow.
  - Push when empty: head valid next cycle (no bypass).
  - Overflow-setting push and clearing read cannot coincide (one req per cycle).
- Reset (reset_n=0 at edge): led=0, seven_seg=0, timer=0, FIFO empty, overflow=0, ack=0, rdata=0, uart_tx_valid=0, uart_tx_data=0 (head reads 0 when empty), synchroniser flops=0. Reset mid-transaction drops the pending ack.

## Timing
- Request in cycle N (req=1) → ack=1 and rdata valid in cycle N+1 only, both registered.
- Writes take effect at edge ending cycle N; a read requested in N+1 sees new value.
- Back-to-back reqs in N, N+1 → acks in N+1, N+2.
- Write acks return rdata=0.
- Free-slot count read reflects pushes/pops completed by edge ending req cycle.
- FIFO pop: data leaves on edge where valid && ready; next head presented the following cycle.

## Test plan
- Reset: hold reset_n=0 2 cycles → led=0, seven_seg=0, ack=0, rdata=0, uart_tx_valid=0; read 0x0C → rdata=0x00000010.
- LED strobes: write 0x04 data 0x3FF wstrb=0001 → read 0x04 returns 0x0FF; then wstrb=0010 data 0x200 → 0x2FF.
- Unmapped/ack shape: read 0x40 → ack one cycle after req, rdata=0; rdata=0 in every non-ack cycle across 100 random accesses.
- FIFO full: uart_tx_ready=0, push 0x41..0x51 (17 bytes) → read 0x0C returns 0x80000000; second read returns 0x00000000; release ready → bytes 0x41..0x50 emerge in order, 0x51 absent.
- Full push+pop: fill FIFO, pulse ready in same cycle as push 0x99 → count stays 16, overflow 0, 0x99 is last byte out.
- Timer: write 0x10, read 0x10 two cycles after write req → value 1; force counter to 0xFFFFFFFF-range via wait/compare → wraps to 0.
